// File: rtl/des_perm_pipe.sv
// Elastic valid/ready pipeline applying the DES initial permutation (mode 0) or its inverse
// (mode 1) per word. Define DES_PERM_SELFCHECK_EN to carry the original word and flag round-trip errors.
module des_perm_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:63]      in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:63]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             err
);

    // Source bit of IP output bit k; FP scatters through the same index.
    function automatic logic [5:0] ip_src(input int unsigned k);
        int unsigned base;
        base = (k < 32) ? 57 : 56;
        return 6'(base + 2 * ((k % 32) / 8) - 8 * (k % 8));
    endfunction

    function automatic logic [0:63] ip_perm(input logic [0:63] d);
        logic [0:63] r;
        r = '0;
        for (int unsigned k = 0; k < 64; k++) begin
            r[6'(k)] = d[ip_src(k)];
        end
        return r;
    endfunction

    function automatic logic [0:63] fp_perm(input logic [0:63] d);
        logic [0:63] r;
        r = '0;
        for (int unsigned k = 0; k < 64; k++) begin
            r[ip_src(k)] = d[6'(k)];
        end
        return r;
    endfunction

    logic [DEPTH-1:0] valid_q;
    logic [0:63]      data_q [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [0:63]      perm_d;

    assign perm_d = in_mode ? fp_perm(in_data) : ip_perm(in_data);

    // A stage may load if it or any stage downstream of it has a hole, or the sink accepts.
    always_comb begin : ready_chain
        logic acc;
        acc = out_ready;
        rdy = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            acc    = acc | ~valid_q[s];
            rdy[s] = acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= '0;
                tag_q[s]  <= '0;
            end
        end else begin
            if (rdy[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= perm_d;
                    tag_q[0]  <= in_tag;
                end
            end
            for (int s = 1; s < DEPTH; s++) begin
                if (rdy[s]) begin
                    valid_q[s] <= valid_q[s-1];
                    if (valid_q[s-1]) begin
                        data_q[s] <= data_q[s-1];
                        tag_q[s]  <= tag_q[s-1];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];
    assign busy      = |valid_q;

`ifdef DES_PERM_SELFCHECK_EN
    logic [DEPTH-1:0] mode_q;
    logic [0:63]      orig_q [DEPTH];
    logic [0:63]      back_d;
    logic             err_q;

    assign back_d = mode_q[DEPTH-1] ? ip_perm(data_q[DEPTH-1]) : fp_perm(data_q[DEPTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (rdy[0] && in_valid) begin
                mode_q[0] <= in_mode;
                orig_q[0] <= in_data;
            end
            for (int s = 1; s < DEPTH; s++) begin
                if (rdy[s] && valid_q[s-1]) begin
                    mode_q[s] <= mode_q[s-1];
                    orig_q[s] <= orig_q[s-1];
                end
            end
            err_q <= err_q | (valid_q[DEPTH-1] & (back_d != orig_q[DEPTH-1]));
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_des_perm_pipe.sv
// Self-checking bench for des_perm_pipe: directed vectors, random streams under backpressure,
// full stall/drain and mid-stream reset, checked against a table-driven DES IP model.
module tb_des_perm_pipe;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [0:63]      in_data;
    logic             in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [0:63]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    logic             err;

    des_perm_pipe #(
        .DEPTH(DEPTH),
        .TAG_W(TAG_W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Standard DES IP table, 1-based source bit numbers, MSB = bit 1.
    int ip_tab [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    typedef struct {
        logic [0:63]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];

    function automatic logic [0:63] m_ip(input logic [0:63] d);
        logic [0:63] r;
        for (int k = 0; k < 64; k++) r[k] = d[ip_tab[k] - 1];
        return r;
    endfunction

    function automatic logic [0:63] m_fp(input logic [0:63] d);
        logic [0:63] r;
        for (int k = 0; k < 64; k++) r[ip_tab[k] - 1] = d[k];
        return r;
    endfunction

    function automatic logic [0:63] model(input logic [0:63] d, input logic m);
        return m ? m_fp(d) : m_ip(d);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; checks the accept-to-output latency of one word.
    task automatic send_one(input logic [0:63] d, input logic m, input logic [TAG_W-1:0] t,
                            input logic [0:63] exp, input string name);
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        in_tag    = t;
        out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (DEPTH - 2) @(posedge clk);
        #1;
        chk({name, "_early"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_data"}, out_data, exp);
        chk({name, "_model"}, out_data, model(d, m));
        chk({name, "_tag"}, 64'(out_tag), 64'(t));
        @(posedge clk);
        #1;
        chk({name, "_gone"}, 64'(out_valid), 64'd0);
    endtask

    // Called at posedge+1; streams n words, random or alternating modes, tags = index.
    task automatic stream(input int n, input int rdy_pct, input bit rand_mode, input string name,
                          output int cycles);
        int          sent = 0;
        int          rcvd = 0;
        bit          stalled = 0;
        bit          acc;
        exp_t        e;
        logic [0:63] cur_d;
        logic        cur_m;
        cur_d     = {$urandom(), $urandom()};
        cur_m     = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        in_valid  = 1'b1;
        in_data   = cur_d;
        in_mode   = cur_m;
        in_tag    = '0;
        out_ready = ($urandom_range(0, 99) < rdy_pct);
        cycles    = 0;
        while (cycles < 2000 && rcvd < n) begin
            @(negedge clk);
            if (stalled) chk({name, "_stall_valid"}, 64'(out_valid), 64'd1);
            if (out_valid) begin
                chk({name, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    chk({name, "_data"}, out_data, sb[0].data);
                    chk({name, "_tag"}, 64'(out_tag), 64'(sb[0].tag));
                    if (out_ready) begin
                        e = sb.pop_front();
                        rcvd++;
                    end
                end
            end
            stalled = out_valid && !out_ready;
            acc     = in_valid && in_ready;
            if (acc) begin
                e.data = model(in_data, in_mode);
                e.tag  = in_tag;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            cycles++;
            if (acc) begin
                sent++;
                cur_d = {$urandom(), $urandom()};
                cur_m = rand_mode ? 1'($urandom_range(0, 1)) : 1'(sent % 2);
            end
            in_valid  = (sent < n);
            in_data   = cur_d;
            in_mode   = cur_m;
            in_tag    = TAG_W'(sent);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
        end
        chk({name, "_count"}, 64'(rcvd), 64'(n));
        chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int   cyc;
        exp_t e;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        send_one(64'h0123456789ABCDEF, 1'b0, 4'd5, 64'hCC00CCFFF0AAF0AA, "ip_vec");
        send_one(64'hCC00CCFFF0AAF0AA, 1'b1, 4'd9, 64'h0123456789ABCDEF, "fp_vec");
        send_one(64'hFFFFFFFFFFFFFFFF, 1'b0, 4'd1, 64'hFFFFFFFFFFFFFFFF, "ones_ip");
        send_one(64'hFFFFFFFFFFFFFFFF, 1'b1, 4'd2, 64'hFFFFFFFFFFFFFFFF, "ones_fp");
        send_one(64'h8000000000000000, 1'b0, 4'd3, 64'h0000000001000000, "bit0_ip");
        send_one(64'h0000000001000000, 1'b1, 4'd4, 64'h8000000000000000, "bit39_fp");

        stream(16, 50, 1'b0, "bp16", cyc);
        stream(24, 100, 1'b1, "full_rate", cyc);
        chk("full_rate_cycles", 64'(cyc), 64'(24 + DEPTH));
        stream(40, 35, 1'b1, "bp_rand", cyc);

        // Fill with the sink blocked, then drain.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            in_data = {$urandom(), $urandom()};
            in_mode = 1'(i % 2);
            in_tag  = TAG_W'(i + 3);
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'(i < DEPTH));
            if (in_ready) begin
                e.data = model(in_data, in_mode);
                e.tag  = in_tag;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_busy", 64'(busy), 64'd1);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_hold_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("drain_valid", 64'(out_valid), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("drain_data", out_data, e.data);
                chk("drain_tag", 64'(out_tag), 64'(e.tag));
            end
        end
        @(negedge clk);
        chk("drain_done_valid", 64'(out_valid), 64'd0);
        chk("drain_done_busy", 64'(busy), 64'd0);
        sb.delete();

        // Reset with three words in flight.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom(), $urandom()};
            in_mode  = 1'(i % 2);
            in_tag   = TAG_W'(i + 10);
            @(negedge clk);
            chk("mid_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("mid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mid_no_stale", 64'(out_valid), 64'd0);
        end

        @(posedge clk);
        #1;
        stream(12, 60, 1'b1, "post_rst", cyc);
        chk("final_err", 64'(err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
